// File: rtl/synch_fifo_gnt_if.sv
// synch_fifo_gnt_if: request-port bundle between a processing element (master) and the grant FIFO (slave)
//   master drives write_en/write_data/read_en/nxt_gnt/err_clr; slave returns data, level and error flags
interface synch_fifo_gnt_if #(
  parameter int FIFO_PTR   = 4,
  parameter int FIFO_WIDTH = 32
);
  logic                  write_en;
  logic [FIFO_WIDTH-1:0] write_data;
  logic                  read_en;
  logic                  nxt_gnt;
  logic                  err_clr;
  logic [FIFO_WIDTH-1:0] read_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [FIFO_PTR:0]     room_avail;
  logic [FIFO_PTR:0]     data_avail;
  logic                  req;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output write_en, write_data, read_en, nxt_gnt, err_clr,
    input  read_data, full, empty, almost_full, almost_empty, room_avail, data_avail, req, overflow, underflow
  );
  modport slave (
    input  write_en, write_data, read_en, nxt_gnt, err_clr,
    output read_data, full, empty, almost_full, almost_empty, room_avail, data_avail, req, overflow, underflow
  );
endinterface

// File: rtl/synch_fifo_gnt.sv
// synch_fifo_gnt: any-depth synchronous FIFO with peek/commit reads, level thresholds and sticky errors
//   clk/rst: rising-edge clock, async active-high reset; bus: slave side of synch_fifo_gnt_if
module synch_fifo_gnt #(
  parameter int FIFO_PTR   = 4,
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic               clk,
  input logic               rst,
  synch_fifo_gnt_if.slave   bus
);
  localparam int CW = FIFO_PTR + 1;
  localparam logic [FIFO_PTR:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [FIFO_PTR:0]   AF_C    = CW'(AF_LEVEL);
  localparam logic [FIFO_PTR:0]   AE_C    = CW'(AE_LEVEL);
  localparam logic [FIFO_PTR-1:0] LAST_C  = FIFO_PTR'(FIFO_DEPTH - 1);
  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_PTR-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_PTR:0]     count_q, count_d;
  logic [FIFO_WIDTH-1:0] read_data_q, read_data_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  full, empty, wr_ok, rd_ok, pop_ok;
  always_comb begin
    full        = count_q == DEPTH_C;
    empty       = count_q == '0;
    wr_ok       = bus.write_en & ~full;
    rd_ok       = bus.read_en & ~empty;
    pop_ok      = rd_ok & bus.nxt_gnt;
    wr_ptr_d    = wr_ok ? (wr_ptr_q == LAST_C ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d    = pop_ok ? (rd_ptr_q == LAST_C ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d     = count_q + CW'(wr_ok) - CW'(pop_ok);
    read_data_d = rd_ok ? mem_q[rd_ptr_q] : read_data_q;
    // a new error in the same cycle as err_clr keeps the flag set
    overflow_d  = (bus.write_en & full) | (overflow_q & ~bus.err_clr);
    underflow_d = (bus.read_en & bus.nxt_gnt & empty) | (underflow_q & ~bus.err_clr);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      read_data_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  always_ff @(posedge clk)
    if (wr_ok) mem_q[wr_ptr_q] <= bus.write_data;
  assign bus.read_data    = read_data_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = count_q >= AF_C;
  assign bus.almost_empty = count_q <= AE_C;
  assign bus.room_avail   = DEPTH_C - count_q;
  assign bus.data_avail   = count_q;
  assign bus.req          = ~empty;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_synch_fifo_gnt.sv
// tb_synch_fifo_gnt: directed scoreboard bench for a depth-16 and a depth-12 grant FIFO
module tb_synch_fifo_gnt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  synch_fifo_gnt_if #(.FIFO_PTR(4), .FIFO_WIDTH(32)) b16 ();
  synch_fifo_gnt_if #(.FIFO_PTR(4), .FIFO_WIDTH(32)) b12 ();
  synch_fifo_gnt u16 (.clk(clk), .rst(rst), .bus(b16.slave));
  synch_fifo_gnt #(.FIFO_DEPTH(12)) u12 (.clk(clk), .rst(rst), .bus(b12.slave));
  int n_chk = 0;
  int n_fail = 0;
  int depth [2] = '{16, 12};
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] rd_m [2] = '{32'h0, 32'h0};
  bit ov_m [2] = '{1'b0, 1'b0};
  bit un_m [2] = '{1'b0, 1'b0};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q0.delete();
    q1.delete();
    rd_m = '{32'h0, 32'h0};
    ov_m = '{1'b0, 1'b0};
    un_m = '{1'b0, 1'b0};
  endtask
  task automatic check(input int s, input string tag);
    int n;
    logic [31:0] rd, da, ra;
    logic fu, em, rq, af, ae, ov, un;
    n = s ? q1.size() : q0.size();
    if (s) begin
      rd = b12.read_data; da = 32'(b12.data_avail); ra = 32'(b12.room_avail); fu = b12.full; em = b12.empty;
      rq = b12.req; af = b12.almost_full; ae = b12.almost_empty; ov = b12.overflow; un = b12.underflow;
    end else begin
      rd = b16.read_data; da = 32'(b16.data_avail); ra = 32'(b16.room_avail); fu = b16.full; em = b16.empty;
      rq = b16.req; af = b16.almost_full; ae = b16.almost_empty; ov = b16.overflow; un = b16.underflow;
    end
    chk({tag, " read_data"}, rd, rd_m[s]);
    chk({tag, " data_avail"}, da, 32'(n));
    chk({tag, " room_avail"}, ra, 32'(depth[s] - n));
    chk({tag, " full"}, 32'(fu), 32'(n == depth[s]));
    chk({tag, " empty"}, 32'(em), 32'(n == 0));
    chk({tag, " req"}, 32'(rq), 32'(n != 0));
    chk({tag, " almost_full"}, 32'(af), 32'(n >= depth[s] - 2));
    chk({tag, " almost_empty"}, 32'(ae), 32'(n <= 2));
    chk({tag, " overflow"}, 32'(ov), 32'(ov_m[s]));
    chk({tag, " underflow"}, 32'(un), 32'(un_m[s]));
  endtask
  task automatic set_in(input int s, input bit we, input logic [31:0] wd, input bit re, input bit ng, input bit ec);
    if (s) begin
      b12.write_en = we; b12.write_data = wd; b12.read_en = re; b12.nxt_gnt = ng; b12.err_clr = ec;
    end else begin
      b16.write_en = we; b16.write_data = wd; b16.read_en = re; b16.nxt_gnt = ng; b16.err_clr = ec;
    end
  endtask
  task automatic cyc(input int s, input string tag, input bit we, input logic [31:0] wd, input bit re, input bit ng, input bit ec);
    int n;
    bit full_m, empty_m;
    logic [31:0] head;
    n = s ? q1.size() : q0.size();
    full_m = n == depth[s];
    empty_m = n == 0;
    head = empty_m ? 32'h0 : (s ? q1[0] : q0[0]);
    set_in(s, we, wd, re, ng, ec);
    @(posedge clk);
    #1;
    set_in(s, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    if (re && !empty_m) rd_m[s] = head;
    if (re && ng && !empty_m) begin
      if (s) void'(q1.pop_front()); else void'(q0.pop_front());
    end
    if (we && !full_m) begin
      if (s) q1.push_back(wd); else q0.push_back(wd);
    end
    ov_m[s] = (we && full_m) || (ov_m[s] && !ec);
    un_m[s] = (re && ng && empty_m) || (un_m[s] && !ec);
    check(s, tag);
  endtask
  initial begin
    set_in(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    set_in(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    check(0, "reset16");
    check(1, "reset12");
    for (int i = 0; i < 16; i++) cyc(0, "fill", 1'b1, ~32'(i + 1), 1'b0, 1'b0, 1'b0);
    cyc(0, "ovf_drop", 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    cyc(0, "err_clr_set_wins", 1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b1);
    cyc(0, "err_clr", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(0, "ovf_with_pop", 1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0);
    cyc(0, "err_clr2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) cyc(0, "drain", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(0, "peek_empty", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(0, "wr_a", 1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cyc(0, "wr_b", 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    cyc(0, "peek1", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(0, "peek2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(0, "pop_a", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(0, "pop_b", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(0, "stream_init", 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cyc(0, "stream", 1'b1, ~32'(i + 1), 1'b1, 1'b1, 1'b0);
    cyc(0, "stream_last", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(0, "wr_rd_empty", 1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
    cyc(0, "pop_77", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1, "w12_fill", 1'b1, 32'(i + 100), 1'b0, 1'b0, 1'b0);
    cyc(1, "w12_ovf", 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    cyc(1, "w12_clr", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1, "w12_pop8", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1, "w12_wrap_wr", 1'b1, 32'(i + 200), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1, "w12_drain", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(1, "w12_udf", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(0, "pre_rst", 1'b1, 32'(i + 300), 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst empty", 32'(b16.empty), 32'h1);
    chk("async_rst data_avail", 32'(b16.data_avail), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check(0, "post_rst16");
    check(1, "post_rst12");
    cyc(0, "rst_wr1", 1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
    cyc(0, "rst_pop1", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("rst_pop1 value", b16.read_data, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
